hashcore_sched: RTL
===================

Name: hashcore_sched

Overview:
Work loader and golden-nonce collector for an array of NCORES hashcore instances sharing one serial work bus.
- Work path: accepts a parallel work word and shifts it MSB-first onto the shared din/shift lines, then strobes loadnonce.
- Nonce path: captures one-cycle golden-nonce strobes from every core, arbitrates them round-robin into a FIFO, and presents them to the comms layer over a valid/ready handshake.
- Placement: between the serial/comms front end and the hashcore array, in the hash_clk domain.

Parameters:
NCORES, 4, number of hashcores served (1..8); also the number of distinct nonce_msb prefixes.
WORK_BITS, 384, width of one work word shifted to the cores.
FIFO_DEPTH, 8, golden-nonce FIFO entries (power of 2, >=2).

Ports:
hash_clk  in  1  clock.
reset_n  in  1  synchronous, active-low reset.
work_data  in  WORK_BITS  work word; bit WORK_BITS-1 is shifted first.
work_valid  in  1  work word offered.
work_ready  out  1  scheduler can accept work.
din  out  1  serial work bit, broadcast to all cores.
shift  out  1  shift enable, broadcast to all cores.
loadnonce  out  1  one-cycle strobe after a load completes.
core_match  in  NCORES  per-core golden_nonce_match strobe.
core_nonce  in  32*NCORES  per-core golden_nonce_out; core i uses bits [32i+31:32i].
gn_valid  out  1  FIFO head valid.
gn_ready  in  1  consumer takes the FIFO head.
gn_nonce  out  32  head nonce.
gn_core  out  3  head core index.
drop_cnt  out  8  saturating count of lost matches.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: on any edge with reset_n=0, all of the following clear to 0: state, shift, din, loadnonce, pending regs, FIFO, RR pointer, drop_cnt. While reset_n=0, gn_valid=0 and work_ready=0 (combinational gating). A reset during SHIFT aborts the load: shift=0 after the next edge and no loadnonce is issued.
- Work FSM states: IDLE, SHIFT, LOAD.
- IDLE: work_ready=1. On work_valid&work_ready at edge k, latch work_data into the shift register and go to SHIFT.
- SHIFT: shift and din are registered. shift=1 for exactly WORK_BITS cycles (k+1..k+WORK_BITS). din=work_data[WORK_BITS-1-j] in shift cycle j (j=0..WORK_BITS-1). A down-counter from WORK_BITS-1 controls the exit.
- LOAD: shift=0, din=0, loadnonce=1 for one cycle (k+WORK_BITS+1). Then IDLE; work_ready=1 from cycle k+WORK_BITS+2.
- work_ready=0 in SHIFT and LOAD; work_valid is ignored there.
- Pending stage: per core i, one register pair pend_v[i]/pend_n[i].
  - If core_match[i]=1 and (pend_v[i]=0, or core i is granted this cycle), load core_nonce[i] and set pend_v[i]=1.
  - Otherwise the match is dropped, and drop_cnt increments by the number of cores dropping that cycle, saturating at 255.
- Arbiter: round-robin over pend_v, one grant per cycle, and only when fifo_level<FIFO_DEPTH (registered level). A push is never made to a full FIFO, even in a cycle that also pops.
  - The granted core writes {core index, pend_n} to the FIFO and clears its pend_v.
  - The RR pointer moves to granted+1 mod NCORES. After reset the pointer is 0.
- FIFO: show-ahead. gn_valid=(level!=0); gn_nonce/gn_core reflect the head. Pop on gn_valid&gn_ready.
  - Simultaneous push and pop: level unchanged.
  - Full FIFO: grants stall, pending regs hold, and new matches on already-pending cores are dropped.
- Latency: match at edge t, pending at t+1, FIFO write at edge t+1, gn_valid=1 from cycle t+2 (FIFO empty, no contention).
- Core index width is fixed at 3 bits; unused upper values never appear.

Optional Feature:
HASHCORE_STALE_FLUSH_EN
- Defined:
  - The work-accept edge clears all pend_v and empties the FIFO. A pop in the same cycle is discarded.
  - core_match is ignored during the accept cycle, SHIFT and LOAD. These matches are stale and are not counted in drop_cnt.
- Undefined: pending regs and the FIFO are retained across work loads, and matches are accepted in every state.

Test Plan:
- Load: work_data=384'h8000...0001 accepted at k → shift=1 for cycles k+1..k+384; din=1 at k+1 and at k+384, 0 otherwise; loadnonce=1 only at k+385; work_ready=1 at k+386.
- Single match: core 2 strobes core_nonce=32'hDEADBEEF at t, gn_ready=1 → gn_valid at t+2 with gn_nonce=DEADBEEF, gn_core=2; gn_valid=0 at t+3.
- Contention: cores 0,1,3 strobe in the same cycle, gn_ready=1, pointer=0 → FIFO order 0,1,3; next contention starts at core 0 (pointer = 3+1 mod 4).
- Overflow: gn_ready=0, 12 distinct-core/serial matches with FIFO_DEPTH=8 → fifo_level=8; 4 pending held; a repeat match on a pending core → drop_cnt+1; 300 forced drops → drop_cnt=255.
- Reset mid-SHIFT: reset_n=0 for one cycle at shift bit 100 → shift=0, no loadnonce, work_ready=1 after reset_n returns high, FIFO empty.
- Flush (HASHCORE_STALE_FLUSH_EN): 3 entries queued, new work accepted → fifo_level=0 the next cycle; match during SHIFT → no FIFO write, drop_cnt unchanged. Without the macro: 3 entries retained and the match is queued.

Source files
------------

// File: rtl/hashcore_sched.sv
// Work loader and golden-nonce collector for an array of hashcores.
// Shifts a parallel work word MSB-first onto the shared din/shift bus, then strobes loadnonce.
// Golden-nonce strobes are held per core, arbitrated round-robin into a show-ahead FIFO,
// and offered to the consumer over gn_valid/gn_ready.
// Optional build macro HASHCORE_STALE_FLUSH_EN: accepting new work flushes pending matches
// and the FIFO, and matches are ignored from the accept cycle until the FSM is back in IDLE.
module hashcore_sched #(
  parameter int unsigned NCORES     = 4,
  parameter int unsigned WORK_BITS  = 384,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                            hash_clk,
  input  logic                            reset_n,
  input  logic [WORK_BITS-1:0]            work_data,
  input  logic                            work_valid,
  output logic                            work_ready,
  output logic                            din,
  output logic                            shift,
  output logic                            loadnonce,
  input  logic [NCORES-1:0]               core_match,
  input  logic [32*NCORES-1:0]            core_nonce,
  output logic                            gn_valid,
  input  logic                            gn_ready,
  output logic [31:0]                     gn_nonce,
  output logic [2:0]                      gn_core,
  output logic [7:0]                      drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int unsigned CntW  = $clog2(WORK_BITS);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

  state_e                   state_q, state_d;
  logic [WORK_BITS-1:0]     shreg_q, shreg_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     shift_q, shift_d;
  logic                     din_q, din_d;
  logic                     loadnonce_q, loadnonce_d;

  logic [NCORES-1:0]        pend_v_q, pend_v_d;
  logic [NCORES-1:0][31:0]  pend_n_q, pend_n_d;
  logic [2:0]               rr_q, rr_d;
  logic [7:0]               drop_cnt_q, drop_cnt_d;

  logic [34:0]              mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]          level_q, level_d;

  logic                     accept, flush, pop;
  logic [NCORES-1:0]        match_m;
  logic                     gnt_vld, push;
  logic [2:0]               gnt_idx;
  logic [NCORES-1:0]        gnt_oh;
  logic [31:0]              gnt_nonce;
  logic [3:0]               drops;
  logic [8:0]               drop_sum;

  assign work_ready = reset_n && (state_q == StIdle);
  assign accept     = work_valid && work_ready;
  assign gn_valid   = reset_n && (level_q != '0);
  assign pop        = gn_valid && gn_ready;
  assign {gn_core, gn_nonce} = mem_q[rd_ptr_q];
  assign shift      = shift_q;
  assign din        = din_q;
  assign loadnonce  = loadnonce_q;
  assign drop_cnt   = drop_cnt_q;
  assign fifo_level = level_q;

`ifdef HASHCORE_STALE_FLUSH_EN
  // Matches seen while a new work word is being loaded belong to the old work.
  assign flush   = accept;
  assign match_m = (accept || (state_q != StIdle)) ? '0 : core_match;
`else
  assign flush   = 1'b0;
  assign match_m = core_match;
`endif

  // Work FSM: latch on accept, emit one bit per cycle, then a single loadnonce strobe.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    shift_d     = 1'b0;
    din_d       = 1'b0;
    loadnonce_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = 1'b1;
          din_d   = work_data[WORK_BITS-1];
          shreg_d = {work_data[WORK_BITS-2:0], 1'b0};
          cnt_d   = CntW'(WORK_BITS - 1);
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q == '0) begin
          loadnonce_d = 1'b1;
          state_d     = StLoad;
        end else begin
          shift_d = 1'b1;
          din_d   = shreg_q[WORK_BITS-1];
          shreg_d = {shreg_q[WORK_BITS-2:0], 1'b0};
          cnt_d   = cnt_q - 1'b1;
        end
      end
      StLoad: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Round-robin arbiter: first pending core at or after rr_q, only if the FIFO has room.
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    gnt_nonce = '0;
    if (level_q < FullLvl) begin
      for (int unsigned off = 0; off < NCORES; off++) begin
        for (int unsigned j = 0; j < NCORES; j++) begin
          if (!gnt_vld && pend_v_q[j] && (j == ((int'(rr_q) + off) % NCORES))) begin
            gnt_vld   = 1'b1;
            gnt_idx   = 3'(j);
            gnt_oh[j] = 1'b1;
            gnt_nonce = pend_n_q[j];
          end
        end
      end
    end
  end

  assign push = gnt_vld && !flush;

  // Pending regs, drop counting and RR pointer update.
  always_comb begin
    pend_v_d = pend_v_q;
    pend_n_d = pend_n_q;
    drops    = '0;
    rr_d     = rr_q;
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (match_m[i] && (!pend_v_q[i] || gnt_oh[i])) begin
        pend_v_d[i] = 1'b1;
        pend_n_d[i] = core_nonce[32*i +: 32];
      end else begin
        if (gnt_oh[i]) pend_v_d[i] = 1'b0;
        if (match_m[i]) drops = drops + 4'd1;
      end
    end
    if (flush) pend_v_d = '0;
    if (push) rr_d = (gnt_idx == 3'(NCORES - 1)) ? 3'd0 : gnt_idx + 3'd1;
    drop_sum   = {1'b0, drop_cnt_q} + {5'd0, drops};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // FIFO pointers and occupancy; a flush discards everything including a same-cycle pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      cnt_q       <= '0;
      shift_q     <= 1'b0;
      din_q       <= 1'b0;
      loadnonce_q <= 1'b0;
      pend_v_q    <= '0;
      pend_n_q    <= '0;
      rr_q        <= '0;
      drop_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      din_q       <= din_d;
      loadnonce_q <= loadnonce_d;
      pend_v_q    <= pend_v_d;
      pend_n_q    <= pend_n_d;
      rr_q        <= rr_d;
      drop_cnt_q  <= drop_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  // FIFO storage; contents are only meaningful below the level, so no reset is needed.
  always_ff @(posedge hash_clk) begin
    if (reset_n && push) mem_q[wr_ptr_q] <= {gnt_idx, gnt_nonce};
  end

endmodule
